// File: rtl/swap_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : swap_arb_pkg                                               |
// | Shared width, arbiter state type and byte-swap helper for the       |
// | swap_pipe_arbiter block.                                             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package swap_arb_pkg;

  localparam int DATA_W = 16;

  // IDLE: any requester may win. LOCKED: only the current owner may be served.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Exchange the high and low bytes of a 16-bit word.
  function automatic logic [DATA_W-1:0] byte_swap16(input logic [DATA_W-1:0] word);
    return {word[7:0], word[15:8]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_pick                                                    |
// | Combinational round-robin picker: the first requester after         |
// | last_grant (wrapping) wins; returns one-hot grant and its index.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  int  rank;
  int  best_rank;
  int  best;
  logic found;

  // Rank each requester by its distance after last_grant; lowest requesting rank wins.
  always_comb begin
    rank      = 0;
    best_rank = NUM_REQ;
    best      = 0;
    found     = 1'b0;
    grant     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rank = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
      if (req[i] && (rank < best_rank)) begin
        best_rank = rank;
        best      = i;
      end
    end
    found = (best_rank < NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = found && (best == i);
    end
    idx = ID_W'(best);
  end

endmodule
`default_nettype wire

// File: rtl/swap_pipe_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : swap_pipe_arbiter                                          |
// | Round-robin, burst-locked arbiter feeding a two-stage registered    |
// | 16-bit byte-swap pipe; output words carry the requester id.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module swap_pipe_arbiter
  import swap_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic [15:0]               beat_count
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

  arb_state_t          state, state_nxt;
  logic [ID_W-1:0]     owner, owner_nxt;
  logic [ID_W-1:0]     last_grant, last_grant_nxt;
  logic [3:0]          burst_cnt, burst_nxt;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  owner_onehot;

  logic                advance;
  logic                accept;
  logic [DATA_W-1:0]   sel_data;
  logic [ID_W-1:0]     sel_id;

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_data;
  logic [ID_W-1:0]     s1_id;

  // The whole pipe moves only when stage 2 is empty or being drained.
  assign advance      = !out_valid || out_ready;
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
  assign accept       = |req_ready;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .idx        (pick_idx)
  );

  // Grant: round-robin winner when idle, owner only when locked; nothing while stalled or in reset.
  always_comb begin
    req_ready = '0;
    if (reset_n && advance) begin
      case (state)
        IDLE:    req_ready = pick_grant;
        LOCKED:  if (req_valid[owner]) req_ready = owner_onehot;
        default: req_ready = '0;
      endcase
    end
  end

  // Mux the granted requester's word and index into stage 1.
  always_comb begin
    sel_data = '0;
    sel_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_id   = ID_W'(i);
      end
    end
  end

  // Arbiter next state: lock onto a winner, count its beats, release on drop or burst limit.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    burst_nxt      = burst_cnt;
    if (advance) begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (MAX_BURST == 1) begin
              last_grant_nxt = pick_idx;
            end else begin
              owner_nxt = pick_idx;
              burst_nxt = 4'd1;
              state_nxt = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (!req_valid[owner]) begin
            last_grant_nxt = owner;
            state_nxt      = IDLE;
          end else if (burst_cnt + 4'd1 == BURST_LAST) begin
            last_grant_nxt = owner;
            state_nxt      = IDLE;
          end else begin
            burst_nxt = burst_cnt + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Arbiter state register; requester 0 has first priority after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  // Two-stage pipe: accepted beat or bubble into stage 1, swapped stage 1 into stage 2.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (advance) begin
      s1_valid  <= accept;
      if (accept) begin
        s1_data <= sel_data;
        s1_id   <= sel_id;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= byte_swap16(s1_data);
        out_id   <= s1_id;
      end
    end
  end

  // Free-running count of accepted input beats, wrapping at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_count <= '0;
    end else if (accept) begin
      beat_count <= beat_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_swap_pipe_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_swap_pipe_arbiter                                       |
// | Self-checking bench: directed scenarios plus random traffic, all    |
// | compared every cycle against a behavioural model.                    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_swap_pipe_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;

  logic                 clock;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic [15:0]          out_data;
  logic [ID_W-1:0]      out_id;
  logic                 out_ready;
  logic [15:0]          beat_count;

  swap_pipe_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST),
    .ID_W      (ID_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .beat_count (beat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: arbitration policy plus a two-slot pipe.
  bit          m_locked;
  int          m_owner, m_burst, m_last, m_beats;
  bit          m_s1v, m_ov;
  logic [15:0] m_s1d, m_od;
  int          m_s1id, m_oid;
  logic [NUM_REQ-1:0] m_acc;
  int          log_id[$];
  logic [15:0] log_data[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_locked = 0; m_owner = 0; m_burst = 0; m_last = NUM_REQ - 1; m_beats = 0;
    m_s1v = 0; m_ov = 0; m_s1d = '0; m_od = '0; m_s1id = 0; m_oid = 0;
    m_acc = '0;
  endfunction

  // Called at posedge+1 with inputs already driven; compares, clocks, advances the model.
  task automatic step();
    bit adv;
    int winner;
    logic [NUM_REQ-1:0] exp_ready;
    #2;
    adv = !m_ov || out_ready;
    winner = -1;
    if (adv) begin
      if (!m_locked) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (m_last + k) % NUM_REQ;
          if (winner < 0 && req_valid[c]) winner = c;
        end
      end else if (req_valid[m_owner]) begin
        winner = m_owner;
      end
    end
    exp_ready = '0;
    if (winner >= 0) exp_ready[winner] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check("out_data", 32'(out_data), 32'(m_od));
      check("out_id", 32'(out_id), 32'(m_oid));
      if (out_ready) begin
        log_id.push_back(m_oid);
        log_data.push_back(m_od);
      end
    end
    check("beat_count", 32'(beat_count), 32'(m_beats % 65536));
    @(posedge clock);
    m_acc = exp_ready;
    if (adv) begin
      m_ov = m_s1v;
      if (m_s1v) begin
        m_od  = {m_s1d[7:0], m_s1d[15:8]};
        m_oid = m_s1id;
      end
      m_s1v = (winner >= 0);
      if (winner >= 0) begin
        m_s1d  = req_data[16*winner +: 16];
        m_s1id = winner;
        m_beats++;
      end
      if (!m_locked) begin
        if (winner >= 0) begin
          if (MAX_BURST == 1) m_last = winner;
          else begin m_locked = 1; m_owner = winner; m_burst = 1; end
        end
      end else begin
        if (winner < 0 || m_burst + 1 == MAX_BURST) begin
          m_last = m_owner; m_locked = 0;
        end else begin
          m_burst++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    log_id.delete();
    log_data.delete();
  endtask

  task automatic peek_ready(input string nm, input logic [NUM_REQ-1:0] exp);
    #1;
    check(nm, 32'(req_ready), 32'(exp));
  endtask

  task automatic set_fixed_data();
    for (int i = 0; i < NUM_REQ; i++) req_data[16*i +: 16] = {8'(8'h10 + i), 8'(8'hC0 + i)};
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] || m_acc[i]) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_data[16*i +: 16] = 16'($urandom);
      end
    end
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '1;
    req_data  = '0;
    out_ready = 1'b1;
    model_reset();

    // Reset with every requester asking.
    @(posedge clock);
    @(posedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_beat_count", 32'(beat_count), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_id", 32'(out_id), 32'h0);
    reset_n = 1'b1;
    peek_ready("first_grant", 4'b0001);
    step();

    // Single requester latency and swap.
    do_reset();
    req_valid = 4'b0100;
    req_data[16*2 +: 16] = 16'h1234;
    step();
    req_valid = '0;
    step();
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_data", 32'(out_data), 32'h3412);
    check("single_id", 32'(out_id), 32'h2);
    step();

    // Burst rotation with all requesters active.
    do_reset();
    set_fixed_data();
    req_valid = '1;
    for (int n = 0; n < 16; n++) step();
    check("burst_beats16", 32'(beat_count), 32'd16);
    for (int n = 0; n < 4; n++) step();
    check("burst_log_len", 32'(log_id.size() >= 17), 32'h1);
    for (int k = 0; k < 17 && k < log_id.size(); k++)
      check($sformatf("burst_id[%0d]", k), 32'(log_id[k]), 32'((k / 4) % 4));

    // Early release: owner 1 drops after two beats, 3 wins over 0.
    do_reset();
    set_fixed_data();
    req_valid = 4'b0010;
    step();
    step();
    req_valid = 4'b1001;
    peek_ready("release_gap", 4'b0000);
    step();
    peek_ready("after_release", 4'b1000);
    step();

    // Backpressure mid-burst.
    do_reset();
    set_fixed_data();
    req_valid = '1;
    step();
    step();
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      check("stall_data", 32'(out_data), 32'h0000C010);
      check("stall_id", 32'(out_id), 32'h0);
      check("stall_ready", 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) step();
    check("bp_log_len", 32'(log_id.size() >= 8), 32'h1);
    for (int k = 0; k < 8 && k < log_id.size(); k++)
      check($sformatf("bp_id[%0d]", k), 32'(log_id[k]), 32'(k / 4));
    if (log_data.size() > 0) check("bp_data0", 32'(log_data[0]), 32'h0000C010);

    // Asynchronous reset mid-burst.
    do_reset();
    set_fixed_data();
    req_valid = '1;
    step();
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'h0);
    check("async_req_ready", 32'(req_ready), 32'h0);
    check("async_beats", 32'(beat_count), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    peek_ready("async_regrant", 4'b0001);
    step();

    // Random traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
